perf_counter_sampler: RTL and testbench
=======================================

Name: perf_counter_sampler

Overview:
- Controller that owns the SRAM-like access port of the performance-counter bank (5-bit address, write enable, XLEN data in/out, combinational read, write applied at next edge).
- Periodically, or on demand, walks a contiguous window of counters and streams each value out on a valid/ready interface for trace/debug export.
- Arbitrates the shared port between the CSR file, which always has priority, and its own sequencer.

Parameters:
- XLEN, 64, counter data width
- NUM_COUNTERS, 14, number of counters per sweep (1..32)
- BASE_ADDR, 5'd0, counter-port address of first counter in sweep; BASE_ADDR+NUM_COUNTERS-1 must be ≤ 31

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clr_i  in  1  synchronous clear: same effect as reset on all state
- enable_i  in  1  enables the periodic timer
- interval_i  in  32  cycles between periodic triggers; 0 = periodic triggering off
- trigger_i  in  1  one-cycle software/debug sweep request
- csr_req_i  in  1  CSR file accessing counter port this cycle
- csr_addr_i  in  5  CSR access address
- csr_we_i  in  1  CSR write enable
- csr_wdata_i  in  XLEN  CSR write data
- csr_rdata_o  out  XLEN  CSR read data
- pc_addr_o  out  5  counter-port address
- pc_we_o  out  1  counter-port write enable
- pc_wdata_o  out  XLEN  counter-port write data
- pc_rdata_i  in  XLEN  counter-port read data (combinational on pc_addr_o)
- sample_valid_o  out  1  sample available
- sample_ready_i  in  1  consumer accepts sample
- sample_data_o  out  XLEN  captured counter value
- sample_idx_o  out  5  sweep index of sample (0..NUM_COUNTERS-1)
- sample_last_o  out  1  sample is last of sweep
- busy_o  out  1  sweep in progress
- overrun_o  out  1  sticky: trigger arrived while busy

Behaviour:
- Reset/clr_i: state IDLE, idx=0, timer=0, all outputs 0, overrun_o=0.
- Timer (32-bit):
  - Runs only when enable_i=1 and interval_i≠0; holds otherwise.
  - Counts up each cycle. When timer==interval_i-1, it reloads to 0 and raises a one-cycle internal periodic trigger.
  - Changing interval_i mid-count takes effect at the next compare; if the new value makes timer ≥ interval_i, the timer wraps through 2^32.
- start = trigger_i | periodic trigger.
  - If start occurs while busy_o=1: the request is dropped and overrun_o is set. overrun_o stays set until reset/clr_i.
  - Simultaneous trigger_i and periodic trigger count as one start.
- FSM:
  - IDLE: on start → READ, idx=0, busy_o=1 from the next cycle.
  - READ: if csr_req_i=1, stall (port granted to CSR). Otherwise drive pc_addr_o=BASE_ADDR+idx, latch pc_rdata_i into sample_data_o and idx into sample_idx_o, then → OUT.
  - OUT: sample_valid_o=1; data/idx/last held stable until handshake. On sample_ready_i: if idx==NUM_COUNTERS-1 → IDLE (busy_o=0 next cycle), else idx++ → READ.
- Minimum cost: 2 cycles per sample, 2·NUM_COUNTERS cycles per sweep with ready tied high and no CSR traffic.
- sample_last_o = (sample_idx_o==NUM_COUNTERS-1) while valid.
- Port mux:
  - csr_req_i=1: pc_addr_o=csr_addr_i, pc_we_o=csr_we_i, pc_wdata_o=csr_wdata_i, csr_rdata_o=pc_rdata_i. This path is purely combinational, 0 latency.
  - csr_req_i=0: csr_rdata_o=0, and pc_we_o=0 except as described under Optional Feature.
- A CSR write to a counter already sampled does not affect the held sample.

Optional Feature:
- Macro PERF_SAMPLER_CLEAR_EN.
- Defined: read-and-clear. In the READ capture cycle, pc_we_o=1 and pc_wdata_o=0. An increment of that counter in the capture cycle is lost, which is accepted.
- Undefined: the sampler never writes; pc_we_o is driven only by the CSR path.

Test Plan:
- interval_i=100, enable_i=1, ready=1, counters preloaded with k+1 → first sweep starts at cycle 100; 14 samples, idx 0..13, data 1..14, last only on idx 13; busy for 28 cycles.
- trigger_i pulse, sample_ready_i low for 10 cycles at idx 3 → valid held 10 cycles with identical data/idx; no port access during the hold; sweep completes.
- csr_req_i=1 for 5 cycles while in READ at idx 6 → pc_addr_o=csr_addr_i throughout, csr_rdata_o matches; sample 6 captured the first cycle csr_req_i drops.
- trigger_i during an active sweep → overrun_o=1 and stays 1; no second sweep; clr_i → overrun_o=0, FSM IDLE.
- PERF_SAMPLER_CLEAR_EN defined, counter 2 = 0x55 → sample 0x55, pc_we_o=1 with wdata 0 in the capture cycle, counter reads 0 afterwards; undefined → pc_we_o never 1 without csr_req_i.
- rst_ni asserted mid-sweep at idx 9 → all outputs 0 immediately (async); after release, IDLE, timer restarts from 0.

Source files
------------

// File: rtl/perf_counter_sampler.sv
// Performance-counter sweep sampler: shares the counter-bank port with the CSR file and streams counter values out.
// Optional read-and-clear of sampled counters is enabled by defining PERF_SAMPLER_CLEAR_EN.
module perf_counter_sampler #(
    parameter int          XLEN         = 64,
    parameter int          NUM_COUNTERS = 14,
    parameter logic [4:0]  BASE_ADDR    = 5'd0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            enable_i,
    input  logic [31:0]     interval_i,
    input  logic            trigger_i,
    input  logic            csr_req_i,
    input  logic [4:0]      csr_addr_i,
    input  logic            csr_we_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic [4:0]      pc_addr_o,
    output logic            pc_we_o,
    output logic [XLEN-1:0] pc_wdata_o,
    input  logic [XLEN-1:0] pc_rdata_i,
    output logic            sample_valid_o,
    input  logic            sample_ready_i,
    output logic [XLEN-1:0] sample_data_o,
    output logic [4:0]      sample_idx_o,
    output logic            sample_last_o,
    output logic            busy_o,
    output logic            overrun_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_COUNTERS - 1);

    state_t            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [31:0]       timer_q, timer_d;
    logic              sample_valid_q, sample_valid_d;
    logic [XLEN-1:0]   sample_data_q, sample_data_d;
    logic [4:0]        sample_idx_q, sample_idx_d;
    logic              sample_last_q, sample_last_d;
    logic              overrun_q, overrun_d;

    logic timer_run;
    logic periodic;
    logic start;
    logic capture;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        timer_d        = timer_q;
        sample_valid_d = sample_valid_q;
        sample_data_d  = sample_data_q;
        sample_idx_d   = sample_idx_q;
        sample_last_d  = sample_last_q;
        overrun_d      = overrun_q;

        // Equality compare only: a shrunken interval lets the timer wrap through 2^32.
        timer_run = enable_i && (interval_i != 32'd0);
        periodic  = timer_run && (timer_q == interval_i - 32'd1);
        if (timer_run) begin
            timer_d = periodic ? 32'd0 : timer_q + 32'd1;
        end

        start   = trigger_i | periodic;
        capture = (state_q == S_READ) && !csr_req_i;

        if (start && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    idx_d   = 5'd0;
                end
            end
            S_READ: begin
                if (capture) begin
                    sample_data_d  = pc_rdata_i;
                    sample_idx_d   = idx_q;
                    sample_last_d  = (idx_q == LAST_IDX);
                    sample_valid_d = 1'b1;
                    state_d        = S_OUT;
                end
            end
            S_OUT: begin
                if (sample_ready_i) begin
                    sample_valid_d = 1'b0;
                    sample_last_d  = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        idx_d   = 5'd0;
                    end else begin
                        state_d = S_READ;
                        idx_d   = idx_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (clr_i) begin
            state_d        = S_IDLE;
            idx_d          = 5'd0;
            timer_d        = 32'd0;
            sample_valid_d = 1'b0;
            sample_data_d  = '0;
            sample_idx_d   = 5'd0;
            sample_last_d  = 1'b0;
            overrun_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            idx_q          <= 5'd0;
            timer_q        <= 32'd0;
            sample_valid_q <= 1'b0;
            sample_data_q  <= '0;
            sample_idx_q   <= 5'd0;
            sample_last_q  <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            timer_q        <= timer_d;
            sample_valid_q <= sample_valid_d;
            sample_data_q  <= sample_data_d;
            sample_idx_q   <= sample_idx_d;
            sample_last_q  <= sample_last_d;
            overrun_q      <= overrun_d;
        end
    end

    // The CSR file always wins the port; the sequencer only touches it in its capture cycle.
    always_comb begin
        pc_addr_o   = 5'd0;
        pc_we_o     = 1'b0;
        pc_wdata_o  = '0;
        csr_rdata_o = '0;
        if (csr_req_i) begin
            pc_addr_o   = csr_addr_i;
            pc_we_o     = csr_we_i;
            pc_wdata_o  = csr_wdata_i;
            csr_rdata_o = pc_rdata_i;
        end else if (capture) begin
            pc_addr_o = BASE_ADDR + idx_q;
`ifdef PERF_SAMPLER_CLEAR_EN
            pc_we_o   = 1'b1;
`else
            pc_we_o   = 1'b0;
`endif
        end
    end

    assign sample_valid_o = sample_valid_q;
    assign sample_data_o  = sample_data_q;
    assign sample_idx_o   = sample_idx_q;
    assign sample_last_o  = sample_last_q;
    assign busy_o         = (state_q != S_IDLE);
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_perf_counter_sampler.sv
// Directed bench for perf_counter_sampler: CSR-mux vector table plus hand-written sweep sequences.
module tb_perf_counter_sampler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        enable;
    logic [31:0] interval;
    logic        trigger;
    logic        csr_req;
    logic [4:0]  csr_addr;
    logic        csr_we;
    logic [63:0] csr_wdata;
    logic [63:0] csr_rdata;
    logic [4:0]  pc_addr;
    logic        pc_we;
    logic [63:0] pc_wdata;
    logic [63:0] pc_rdata;
    logic        sample_valid;
    logic        sample_ready;
    logic [63:0] sample_data;
    logic [4:0]  sample_idx;
    logic        sample_last;
    logic        busy;
    logic        overrun;

    always #5 clk = ~clk;

    perf_counter_sampler #(
        .XLEN(64), .NUM_COUNTERS(14), .BASE_ADDR(5'd0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .enable_i(enable),
        .interval_i(interval), .trigger_i(trigger),
        .csr_req_i(csr_req), .csr_addr_i(csr_addr), .csr_we_i(csr_we),
        .csr_wdata_i(csr_wdata), .csr_rdata_o(csr_rdata),
        .pc_addr_o(pc_addr), .pc_we_o(pc_we), .pc_wdata_o(pc_wdata),
        .pc_rdata_i(pc_rdata),
        .sample_valid_o(sample_valid), .sample_ready_i(sample_ready),
        .sample_data_o(sample_data), .sample_idx_o(sample_idx),
        .sample_last_o(sample_last), .busy_o(busy), .overrun_o(overrun)
    );

    // Counter bank model: combinational read, write at the clock edge.
    logic [63:0] mem [32];
    assign pc_rdata = mem[pc_addr];
    always @(posedge clk) begin
        if (pc_we) mem[pc_addr] <= pc_wdata;
    end

    typedef struct packed {
        logic [4:0]  idx;
        logic [63:0] data;
        logic        last;
    } smp_t;

    smp_t q[$];
    int   stray = 0;
    int   nz_wdata = 0;

    always @(posedge clk) begin
        if (rst_n && sample_valid && sample_ready)
            q.push_back('{idx: sample_idx, data: sample_data, last: sample_last});
        if (rst_n && pc_we && !csr_req) begin
            stray++;
            if (pc_wdata != 64'd0) nz_wdata++;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_valid"}, 64'(sample_valid), 64'd0);
        check({tag, "_data"}, sample_data, 64'd0);
        check({tag, "_idx"}, 64'(sample_idx), 64'd0);
        check({tag, "_last"}, 64'(sample_last), 64'd0);
        check({tag, "_overrun"}, 64'(overrun), 64'd0);
        check({tag, "_pc_addr"}, 64'(pc_addr), 64'd0);
        check({tag, "_pc_we"}, 64'(pc_we), 64'd0);
        check({tag, "_csr_rdata"}, csr_rdata, 64'd0);
    endtask

    function automatic logic [63:0] preload_val(input int k);
        if (k < 14) return 64'(k + 1);
        if (k == 20) return 64'hABCD;
        return 64'h1000 + 64'(k);
    endfunction

    task automatic csr_write(input logic [4:0] a, input logic [63:0] d);
        csr_req = 1'b1; csr_addr = a; csr_we = 1'b1; csr_wdata = d;
        step;
        csr_req = 1'b0; csr_we = 1'b0; csr_wdata = 64'd0; csr_addr = 5'd0;
    endtask

    task automatic preload;
        for (int k = 0; k < 32; k++) csr_write(5'(k), preload_val(k));
    endtask

    task automatic pulse_trigger;
        trigger = 1'b1;
        step;
        trigger = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 400) begin step; n++; end
        check({tag, "_idle_timeout"}, 64'(busy), 64'd0);
    endtask

    task automatic wait_valid_idx(input string tag, input logic [4:0] idx);
        int n = 0;
        while (!(sample_valid && sample_idx == idx) && n < 400) begin step; n++; end
        check({tag, "_reach_idx"}, {58'd0, sample_valid, sample_idx}, {58'd0, 1'b1, idx});
    endtask

    task automatic verify_sweep(input string tag, input int base, input logic [63:0] d2);
        logic [63:0] exp;
        check({tag, "_count"}, 64'(q.size() - base), 64'd14);
        for (int i = 0; i < 14 && base + i < q.size(); i++) begin
            exp = (i == 2) ? d2 : 64'(i + 1);
            $display("%s sample idx=%0d data=%h last=%0d", tag, q[base+i].idx, q[base+i].data, q[base+i].last);
            check({tag, "_idx"}, 64'(q[base+i].idx), 64'(i));
            check({tag, "_data"}, q[base+i].data, exp);
            check({tag, "_last"}, 64'(q[base+i].last), 64'(i == 13));
        end
    endtask

    typedef struct {
        logic        req;
        logic [4:0]  addr;
        logic        we;
        logic [63:0] wdata;
        logic [4:0]  exp_addr;
        logic        exp_we;
        logic [63:0] exp_wdata;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int cnt;
        int base;
        int stray_base;
        int nz_base;

        vecs[0] = '{1'b1, 5'd20, 1'b0, 64'h0,    5'd20, 1'b0, 64'h0,    64'hABCD};
        vecs[1] = '{1'b1, 5'd30, 1'b1, 64'hDEAD, 5'd30, 1'b1, 64'hDEAD, 64'h101E};
        vecs[2] = '{1'b1, 5'd30, 1'b0, 64'h7,    5'd30, 1'b0, 64'h7,    64'hDEAD};
        vecs[3] = '{1'b0, 5'd30, 1'b1, 64'h1234, 5'd0,  1'b0, 64'h0,    64'h0};
        vecs[4] = '{1'b1, 5'd31, 1'b0, 64'h0,    5'd31, 1'b0, 64'h0,    64'h101F};
        vecs[5] = '{1'b1, 5'd30, 1'b0, 64'h0,    5'd30, 1'b0, 64'h0,    64'hDEAD};

        rst_n = 1'b0; clr = 1'b0; enable = 1'b0; interval = 32'd0; trigger = 1'b0;
        csr_req = 1'b0; csr_addr = 5'd0; csr_we = 1'b0; csr_wdata = 64'd0; sample_ready = 1'b1;
        step; step;
        check_all_zero("reset");
        rst_n = 1'b1;
        step;
        preload;

        // CSR port mux vectors
        for (int i = 0; i < 6; i++) begin
            csr_req = vecs[i].req; csr_addr = vecs[i].addr; csr_we = vecs[i].we; csr_wdata = vecs[i].wdata;
            #1;
            $display("vec %0d req=%0d addr=%0d pc_addr=%0d rdata=%h", i, csr_req, csr_addr, pc_addr, csr_rdata);
            check("vec_pc_addr", 64'(pc_addr), 64'(vecs[i].exp_addr));
            check("vec_pc_we", 64'(pc_we), 64'(vecs[i].exp_we));
            check("vec_pc_wdata", pc_wdata, vecs[i].exp_wdata);
            check("vec_csr_rdata", csr_rdata, vecs[i].exp_rdata);
            step;
        end
        csr_req = 1'b0; csr_we = 1'b0; csr_wdata = 64'd0; csr_addr = 5'd0;
        csr_write(5'd30, preload_val(30));

        // Periodic sweep: first start after 100 cycles, 28 busy cycles
        base = q.size();
        enable = 1'b1; interval = 32'd100;
        n = 0;
        while (n < 300) begin step; n++; if (busy) break; end
        check("periodic_start_cycle", 64'(n), 64'd100);
        cnt = 0;
        while (busy && cnt < 100) begin cnt++; step; end
        check("periodic_busy_len", 64'(cnt), 64'd28);
        enable = 1'b0; interval = 32'd0;
        verify_sweep("periodic", base, 64'd3);

        // interval 0 disables the timer
        enable = 1'b1; cnt = 0;
        for (int i = 0; i < 150; i++) begin step; if (busy) cnt++; end
        check("interval0_no_sweep", 64'(cnt), 64'd0);
        enable = 1'b0;

        // Backpressure hold at idx 3, with a CSR write to the held counter
        preload;
        base = q.size();
        pulse_trigger;
        wait_valid_idx("hold", 5'd3);
        sample_ready = 1'b0;
        for (int c = 1; c < 10; c++) begin
            step;
            if (csr_req) begin csr_req = 1'b0; csr_we = 1'b0; csr_addr = 5'd0; csr_wdata = 64'd0; end
            if (c == 4) begin csr_req = 1'b1; csr_addr = 5'd3; csr_we = 1'b1; csr_wdata = 64'h999; end
            #1;
            check("hold_valid", 64'(sample_valid), 64'd1);
            check("hold_idx", 64'(sample_idx), 64'd3);
            check("hold_data", sample_data, 64'd4);
            if (!csr_req) begin
                check("hold_no_we", 64'(pc_we), 64'd0);
                check("hold_no_addr", 64'(pc_addr), 64'd0);
            end
        end
        sample_ready = 1'b1;
        step;
        wait_idle("hold");
        verify_sweep("hold", base, 64'd3);

        // CSR stall at idx 6
        preload;
        base = q.size();
        pulse_trigger;
        wait_valid_idx("stall", 5'd5);
        step;
        csr_req = 1'b1; csr_addr = 5'd20; csr_we = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall_pc_addr", 64'(pc_addr), 64'd20);
            check("stall_csr_rdata", csr_rdata, 64'hABCD);
            check("stall_valid", 64'(sample_valid), 64'd0);
            step;
        end
        csr_req = 1'b0; csr_addr = 5'd0;
        #1;
        check("stall_release_valid", 64'(sample_valid), 64'd0);
        check("stall_release_addr", 64'(pc_addr), 64'd6);
        step;
        check("stall_cap_valid", 64'(sample_valid), 64'd1);
        check("stall_cap_idx", 64'(sample_idx), 64'd6);
        check("stall_cap_data", sample_data, 64'd7);
        wait_idle("stall");
        verify_sweep("stall", base, 64'd3);

        // Overrun: trigger while busy
        preload;
        base = q.size();
        pulse_trigger;
        check("ovr_before", 64'(overrun), 64'd0);
        step; step; step;
        pulse_trigger;
        check("ovr_set", 64'(overrun), 64'd1);
        wait_idle("ovr");
        cnt = 0;
        for (int i = 0; i < 30; i++) begin step; if (busy) cnt++; end
        check("ovr_no_second_sweep", 64'(cnt), 64'd0);
        check("ovr_sticky", 64'(overrun), 64'd1);
        check("ovr_one_sweep", 64'(q.size() - base), 64'd14);
        clr = 1'b1; step; clr = 1'b0;
        check("clr_overrun", 64'(overrun), 64'd0);
        check("clr_busy", 64'(busy), 64'd0);
        pulse_trigger;
        step; step; step; step; step;
        clr = 1'b1; step; clr = 1'b0;
        check_all_zero("clr_mid");

        // Read-and-clear option
        preload;
        csr_write(5'd2, 64'h55);
        base = q.size();
        stray_base = stray;
        nz_base = nz_wdata;
        pulse_trigger;
        wait_idle("rc");
        verify_sweep("rc", base, 64'h55);
`ifdef PERF_SAMPLER_CLEAR_EN
        check("rc_clear_writes", 64'(stray - stray_base), 64'd14);
        check("rc_clear_wdata_zero", 64'(nz_wdata - nz_base), 64'd0);
        check("rc_counter2_after", mem[2], 64'd0);
`else
        check("rc_no_sampler_write", 64'(stray - stray_base), 64'd0);
        check("rc_counter2_after", mem[2], 64'h55);
`endif

        // Async reset mid-sweep, timer restarts from 0
        enable = 1'b1; interval = 32'd1000;
        preload;
        pulse_trigger;
        wait_valid_idx("rst", 5'd9);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        step;
        rst_n = 1'b1; interval = 32'd7;
        n = 0;
        while (n < 50) begin step; n++; if (busy) break; end
        check("rst_timer_restart", 64'(n), 64'd7);
        enable = 1'b0; interval = 32'd0;
        wait_idle("rst");

`ifndef PERF_SAMPLER_CLEAR_EN
        check("never_sampler_write", 64'(stray), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
